// File: rtl/dbg_scan_arb.sv
// Debug readout sequencer: on each display tick it fetches the next RF or DM word; the CPU has priority on the shared DM port.
// Build option DBG_STARVE_GUARD_EN adds a STEAL state that stalls the CPU for one cycle after a long debug wait.
module dbg_scan_arb #(
  parameter int RF_DEPTH   = 32,
  parameter int DM_SHOW    = 8,
  parameter int STARVE_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        scan_en,
  input  logic        scan_sel,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  input  logic        cpu_dm_req,
  input  logic [5:0]  cpu_dm_addr,
  output logic [5:0]  dm_addr,
  input  logic [31:0] dm_rdata,
  output logic        dbg_grant,
  output logic        cpu_stall,
  output logic [31:0] disp_data,
  output logic        disp_valid,
  output logic [5:0]  scan_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    STEAL = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  scan_idx_q, scan_idx_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] disp_data_q, disp_data_d;
  logic        disp_valid_q, disp_valid_d;
  logic        scan_sel_q, scan_sel_d;

  logic        sel_change;
  logic        live;
  logic        starve_hit;
  logic [3:0]  wait_inc;
  logic [5:0]  end_idx;
  logic [31:0] fetch_data;

  // A source switch or scan disable aborts the cycle, so no grant or stall may leak out.
  assign sel_change = (scan_sel != scan_sel_q);
  assign live       = scan_en && !sel_change;
  assign wait_inc   = (wait_cnt_q == 4'hF) ? 4'hF : wait_cnt_q + 4'd1;
  assign end_idx    = scan_sel_q ? 6'(DM_SHOW) : 6'(RF_DEPTH);
  assign fetch_data = scan_sel ? dm_rdata : rf_rdata;

`ifdef DBG_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  assign starve_hit = (wait_inc >= STARVE_LIM);
  assign cpu_stall  = live && (state_q == STEAL);
`else
  logic unused_starve_max;
  assign unused_starve_max = ^32'(STARVE_MAX);
  assign starve_hit        = 1'b0;
  assign cpu_stall         = 1'b0;
`endif

  assign dbg_grant = live && scan_sel &&
                     (((state_q == REQ) && !cpu_dm_req) || (state_q == STEAL));
  assign dm_addr    = dbg_grant ? scan_idx_q : cpu_dm_addr;
  assign rf_raddr   = scan_idx_q[4:0];
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign scan_idx   = scan_idx_q;

  always_comb begin
    state_d      = state_q;
    scan_idx_d   = scan_idx_q;
    wait_cnt_d   = wait_cnt_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = 1'b0;
    scan_sel_d   = scan_sel;

    if (sel_change) begin
      state_d    = IDLE;
      scan_idx_d = 6'd0;
      wait_cnt_d = 4'd0;
    end else if (!scan_en) begin
      state_d    = IDLE;
      wait_cnt_d = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick) begin
            // Past the last entry: show the end marker and wrap without a read.
            if (scan_idx_q >= end_idx) begin
              disp_data_d  = 32'hFFFF_FFFF;
              disp_valid_d = 1'b1;
              scan_idx_d   = 6'd0;
            end else begin
              state_d = REQ;
            end
          end
        end
        REQ: begin
          if (!scan_sel || !cpu_dm_req) begin
            disp_data_d  = fetch_data;
            disp_valid_d = 1'b1;
            scan_idx_d   = scan_idx_q + 6'd1;
            wait_cnt_d   = 4'd0;
            state_d      = IDLE;
          end else begin
            wait_cnt_d = wait_inc;
            if (starve_hit) begin
              state_d = STEAL;
            end
          end
        end
        STEAL: begin
          disp_data_d  = fetch_data;
          disp_valid_d = 1'b1;
          scan_idx_d   = scan_idx_q + 6'd1;
          wait_cnt_d   = 4'd0;
          state_d      = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      scan_idx_q   <= 6'd0;
      wait_cnt_q   <= 4'd0;
      disp_data_q  <= 32'd0;
      disp_valid_q <= 1'b0;
      scan_sel_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      scan_idx_q   <= scan_idx_d;
      wait_cnt_q   <= wait_cnt_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      scan_sel_q   <= scan_sel_d;
    end
  end

endmodule

// File: tb/tb_dbg_scan_arb.sv
// Directed bench for dbg_scan_arb: expected display words are queued at tick time and
// popped by a monitor whenever disp_valid is seen; control outputs are checked inline.
module tb_dbg_scan_arb;
  logic        clk = 1'b0;
  logic        rst, tick, scan_en, scan_sel, cpu_dm_req;
  logic [5:0]  cpu_dm_addr, dm_addr, scan_idx;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata, dm_rdata, disp_data;
  logic        dbg_grant, cpu_stall, disp_valid;

  logic [31:0] rf_mem [0:31];
  logic [31:0] dm_mem [0:63];
  logic [31:0] exp_q [$];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  assign rf_rdata = rf_mem[rf_raddr];
  assign dm_rdata = dm_mem[dm_addr];

  dbg_scan_arb dut (
    .clk(clk), .rst(rst), .tick(tick), .scan_en(scan_en), .scan_sel(scan_sel),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .cpu_dm_req(cpu_dm_req),
    .cpu_dm_addr(cpu_dm_addr), .dm_addr(dm_addr), .dm_rdata(dm_rdata),
    .dbg_grant(dbg_grant), .cpu_stall(cpu_stall), .disp_data(disp_data),
    .disp_valid(disp_valid), .scan_idx(scan_idx)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  // Monitor: every display update must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && disp_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_valid: got disp_valid=1 data %h, expected no update at %0t",
                 disp_data, $time);
      end else begin
        chk("disp_data", disp_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000_0000 + 32'(i);
    rf_mem[3] = 32'h0000_00AB;
    for (int i = 0; i < 64; i++) dm_mem[i] = 32'hD0D0_0000 + 32'(i);

    rst = 1'b1; tick = 1'b0; scan_en = 1'b0; scan_sel = 1'b0;
    cpu_dm_req = 1'b1; cpu_dm_addr = 6'h2A;
    step(2);
    @(negedge clk);
    chk("rst_disp_data", disp_data, 32'h0);
    chk("rst_disp_valid", 32'(disp_valid), 32'h0);
    chk("rst_grant", 32'(dbg_grant), 32'h0);
    chk("rst_stall", 32'(cpu_stall), 32'h0);
    chk("rst_rf_raddr", 32'(rf_raddr), 32'h0);
    chk("rst_scan_idx", 32'(scan_idx), 32'h0);
    chk("rst_dm_addr", 32'(dm_addr), 32'h2A);
    rst = 1'b0; scan_en = 1'b1;
    step(2);

    // Register file: entries 0..2, then entry 3 with CPU DM traffic present.
    exp_q.push_back(32'h1000_0000);
    do_tick(); step(3);
    exp_q.push_back(32'h1000_0001);
    do_tick(); step(3);
    exp_q.push_back(32'h1000_0002);
    do_tick(); step(3);
    exp_q.push_back(32'h0000_00AB);
    do_tick();
    @(negedge clk);
    chk("rf_raddr_3", 32'(rf_raddr), 32'd3);
    chk("rf_no_grant", 32'(dbg_grant), 32'h0);
    chk("rf_dm_addr_cpu", 32'(dm_addr), 32'h2A);
    step(1);
    @(negedge clk);
    chk("rf_valid_t2", 32'(disp_valid), 32'h1);
    chk("rf_scan_idx_4", 32'(scan_idx), 32'd4);
    step(1);
    @(negedge clk);
    chk("rf_valid_pulse", 32'(disp_valid), 32'h0);

    // Data memory full scan: 8 words then end marker, wrap to 0.
    cpu_dm_req = 1'b0; scan_sel = 1'b1;
    step(2);
    @(negedge clk);
    chk("dm_sel_idx0", 32'(scan_idx), 32'd0);
    step(1);
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back((i < 8) ? (32'hD0D0_0000 + 32'(i)) : 32'hFFFF_FFFF);
      do_tick();
      if (i == 0) begin
        @(negedge clk);
        chk("dm_grant", 32'(dbg_grant), 32'h1);
        chk("dm_addr_idx", 32'(dm_addr), 32'd0);
      end
      step(3);
    end
    @(negedge clk);
    chk("dm_wrap_idx", 32'(scan_idx), 32'd0);
    step(1);

    // CPU contention for 5 cycles; a tick arriving in REQ is dropped.
    cpu_dm_req = 1'b1; cpu_dm_addr = 6'h15;
    exp_q.push_back(32'hD0D0_0000);
    do_tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("cont_grant", 32'(dbg_grant), 32'h0);
      chk("cont_stall", 32'(cpu_stall), 32'h0);
      chk("cont_dm_addr", 32'(dm_addr), 32'h15);
      step(1);
      tick = (k == 1);
    end
    tick = 1'b0;
    cpu_dm_req = 1'b0;
    @(negedge clk);
    chk("cont_grant6", 32'(dbg_grant), 32'h1);
    chk("cont_dm_addr6", 32'(dm_addr), 32'd0);
    step(1);
    @(negedge clk);
    chk("cont_valid", 32'(disp_valid), 32'h1);
    step(3);

    // Long contention: guard build steals after 15 waits, default build waits on.
    cpu_dm_req = 1'b1;
    exp_q.push_back(32'hD0D0_0001);
    do_tick();
`ifdef DBG_STARVE_GUARD_EN
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("starve_wait_grant", 32'(dbg_grant), 32'h0);
      chk("starve_wait_stall", 32'(cpu_stall), 32'h0);
      step(1);
    end
    @(negedge clk);
    chk("steal_stall", 32'(cpu_stall), 32'h1);
    chk("steal_grant", 32'(dbg_grant), 32'h1);
    chk("steal_dm_addr", 32'(dm_addr), 32'd1);
    step(1);
    @(negedge clk);
    chk("steal_stall_once", 32'(cpu_stall), 32'h0);
    chk("steal_valid", 32'(disp_valid), 32'h1);
    cpu_dm_req = 1'b0;
    step(3);
`else
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("long_wait_grant", 32'(dbg_grant), 32'h0);
      chk("long_wait_stall", 32'(cpu_stall), 32'h0);
      step(1);
    end
    cpu_dm_req = 1'b0;
    @(negedge clk);
    chk("long_grant", 32'(dbg_grant), 32'h1);
    step(1);
    @(negedge clk);
    chk("long_valid", 32'(disp_valid), 32'h1);
    step(3);
`endif

    // scan_sel toggle while in REQ aborts without a display update.
    cpu_dm_req = 1'b1;
    do_tick();
    step(1);
    scan_sel = 1'b0;
    @(negedge clk);
    chk("toggle_grant", 32'(dbg_grant), 32'h0);
    chk("toggle_stall", 32'(cpu_stall), 32'h0);
    step(1);
    @(negedge clk);
    chk("toggle_idx", 32'(scan_idx), 32'd0);
    chk("toggle_hold", disp_data, 32'hD0D0_0001);
    chk("toggle_no_valid", 32'(disp_valid), 32'h0);
    cpu_dm_req = 1'b0;
    step(2);
    exp_q.push_back(32'h1000_0000);
    do_tick(); step(3);

    // scan_en low ignores ticks and holds scan_idx.
    scan_en = 1'b0;
    do_tick(); step(2);
    @(negedge clk);
    chk("en_off_idx", 32'(scan_idx), 32'd1);
    scan_en = 1'b1;
    step(1);

    // Tick coinciding with a scan_sel change is dropped.
    scan_sel = 1'b1;
    do_tick(); step(3);
    @(negedge clk);
    chk("sel_tick_drop_idx", 32'(scan_idx), 32'd0);
    step(1);

    // Reset in the middle of a contended REQ.
    exp_q.push_back(32'hD0D0_0000);
    do_tick(); step(3);
    cpu_dm_req = 1'b1; cpu_dm_addr = 6'h33;
    do_tick();
    step(1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_disp_data", disp_data, 32'h0);
    chk("midrst_valid", 32'(disp_valid), 32'h0);
    chk("midrst_grant", 32'(dbg_grant), 32'h0);
    chk("midrst_stall", 32'(cpu_stall), 32'h0);
    chk("midrst_rf_raddr", 32'(rf_raddr), 32'h0);
    chk("midrst_idx", 32'(scan_idx), 32'h0);
    chk("midrst_dm_addr", 32'(dm_addr), 32'h33);
    step(2);
    rst = 1'b0; cpu_dm_req = 1'b0;
    step(2);
    exp_q.push_back(32'hD0D0_0000);
    do_tick(); step(5);

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
